// File: rtl/traffic_scheduler.sv
// rtl/traffic_scheduler.sv - shared frame divider, game phase sequencer and per-lane step strobes
//
// Ports:
//    i_Clk        system clock
//    i_Reset      synchronous active-high reset
//    i_start      pulse: leave IDLE and load a new game (level back to 0)
//    i_pause      pulse: toggle RUN <-> PAUSED
//    i_level_up   pulse: bump level (saturating) and reload the lanes
//    i_game_over  pulse: back to IDLE, level kept for the score display
//    o_lane_step  per-lane one-cycle strobe: move that lane's cars one column
//    o_load       one-cycle strobe: cars return to their start positions
//    o_level      current level
//    o_running    high while in RUN
module traffic_scheduler #(
   parameter int unsigned TICK_DIV     = 1250000,
   parameter int unsigned NUM_LANES    = 4,
   parameter logic [31:0] LANE_PERIODS = 32'h0000_6548,
   parameter int unsigned MAX_LEVEL    = 7
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset,
   input  logic                 i_start,
   input  logic                 i_pause,
   input  logic                 i_level_up,
   input  logic                 i_game_over,
   output logic [NUM_LANES-1:0] o_lane_step,
   output logic                 o_load,
   output logic [2:0]           o_level,
   output logic                 o_running
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RUN    = 2'd2,
      ST_PAUSED = 2'd3
   } state_t;

   localparam logic [23:0] FRAME_LAST = 24'(TICK_DIV - 1);
   localparam logic [2:0]  LEVEL_MAX  = 3'(MAX_LEVEL);

   state_t                      state_q, state_d;
   logic [23:0]                 frame_q, frame_d;
   logic [NUM_LANES-1:0][3:0]   lane_q, lane_d;
   logic [2:0]                  level_q, level_d;
   logic [NUM_LANES-1:0]        step_q, step_d;
   logic                        load_q, load_d;
   logic                        running_q, running_d;
   logic                        clear_cnt;
   logic                        count_en;

   // Effective period max(1, p - lvl) in 5-bit arithmetic; the compare
   // guards the subtraction so it never wraps.
   function automatic logic [4:0] eff_period(input logic [3:0] p, input logic [2:0] lvl);
      logic [4:0] diff;
      diff = {1'b0, p} - {2'b00, lvl};
      if ({1'b0, p} > {2'b00, lvl}) begin
         return diff;
      end
      return 5'd1;
   endfunction

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      lane_d    = lane_q;
      level_d   = level_q;
      step_d    = '0;
      clear_cnt = 1'b0;
      count_en  = 1'b0;

      if (i_game_over) begin
         state_d   = ST_IDLE;
         clear_cnt = 1'b1;
      end else if (i_level_up && (state_q == ST_RUN || state_q == ST_PAUSED)) begin
         if (level_q < LEVEL_MAX) begin
            level_d = level_q + 3'd1;
         end
         state_d   = ST_LOAD;
         // Counters restart, which also drops any coinciding frame event.
         clear_cnt = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               clear_cnt = 1'b1;
               if (i_start) begin
                  state_d = ST_LOAD;
                  level_d = 3'd0;
               end
            end
            ST_LOAD: begin
               clear_cnt = 1'b1;
               state_d   = ST_RUN;
            end
            ST_RUN: begin
               // The cycle carrying the pause pulse still counts; freezing
               // starts once the state register reads PAUSED.
               count_en = 1'b1;
               if (i_pause) begin
                  state_d = ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               if (i_pause) begin
                  state_d = ST_RUN;
               end
            end
         endcase
      end

      if (clear_cnt) begin
         frame_d = '0;
         lane_d  = '0;
      end else if (count_en) begin
         if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
               // A zero base period disables the lane entirely.
               if (LANE_PERIODS[4*i +: 4] != 4'd0) begin
                  if ({1'b0, lane_q[i]} >= eff_period(LANE_PERIODS[4*i +: 4], level_q) - 5'd1) begin
                     lane_d[i] = 4'd0;
                     step_d[i] = 1'b1;
                  end else begin
                     lane_d[i] = lane_q[i] + 4'd1;
                  end
               end
            end
         end else begin
            frame_d = frame_q + 24'd1;
         end
      end

      // Outputs are registered copies of the next state, so o_load is high
      // exactly while the state register reads LOAD.
      load_d    = (state_d == ST_LOAD);
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         lane_q    <= '0;
         level_q   <= 3'd0;
         step_q    <= '0;
         load_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         lane_q    <= lane_d;
         level_q   <= level_d;
         step_q    <= step_d;
         load_q    <= load_d;
         running_q <= running_d;
      end
   end

   assign o_lane_step = step_q;
   assign o_load      = load_q;
   assign o_level     = level_q;
   assign o_running   = running_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb/tb_traffic_scheduler.sv - directed self-checking bench for traffic_scheduler
module tb_traffic_scheduler;

   logic       clk = 1'b0;
   logic       rst, start, pause, level_up, game_over;
   logic       rst_b, start_b;
   logic [3:0] step_a, step_b;
   logic       load_a, load_b;
   logic [2:0] level_a, level_b;
   logic       running_a, running_b;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int c0      = 0;

   always #5 clk = ~clk;

   traffic_scheduler #(.TICK_DIV(4), .NUM_LANES(4), .LANE_PERIODS(32'h0000_6548), .MAX_LEVEL(7)) dut_a (
      .i_Clk(clk), .i_Reset(rst), .i_start(start), .i_pause(pause),
      .i_level_up(level_up), .i_game_over(game_over),
      .o_lane_step(step_a), .o_load(load_a), .o_level(level_a), .o_running(running_a)
   );

   traffic_scheduler #(.TICK_DIV(4), .NUM_LANES(4), .LANE_PERIODS(32'h0000_0040), .MAX_LEVEL(7)) dut_b (
      .i_Clk(clk), .i_Reset(rst_b), .i_start(start_b), .i_pause(1'b0),
      .i_level_up(1'b0), .i_game_over(1'b0),
      .o_lane_step(step_b), .o_load(load_b), .o_level(level_b), .o_running(running_b)
   );

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      bit quiet;
      rst = 1'b1; rst_b = 1'b1;
      start = 1'b0; pause = 1'b0; level_up = 1'b0; game_over = 1'b0; start_b = 1'b0;
      repeat (3) step();
      vectors++;
      if ({step_a, load_a, level_a, running_a} !== 9'd0) begin
         errors++;
         $display("FAIL reset_state_a: got %b, expected 000000000", {step_a, load_a, level_a, running_a});
      end
      vectors++;
      if ({step_b, load_b, level_b, running_b} !== 9'd0) begin
         errors++;
         $display("FAIL reset_state_b: got %b, expected 000000000", {step_b, load_b, level_b, running_b});
      end
      rst = 1'b0; rst_b = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if ({step_a, load_a, level_a, running_a} !== 9'd0) quiet = 1'b0;
      end
      vectors++;
      if (!quiet) begin
         errors++;
         $display("FAIL idle_quiet: outputs active during idle, expected all 0");
      end
   endtask

   task automatic test_start_rates();
      int cnt [4];
      int tm [4][8];
      int exp_per [4] = '{32, 16, 20, 24};
      int exp_cnt [4] = '{3, 6, 4, 4};
      bit ok;
      start = 1'b1; step(); start = 1'b0;
      vectors++;
      if (load_a !== 1'b1 || running_a !== 1'b0) begin
         errors++;
         $display("FAIL load_pulse: o_load=%b o_running=%b, expected 1 0", load_a, running_a);
      end
      step();
      vectors++;
      if (load_a !== 1'b0 || running_a !== 1'b1) begin
         errors++;
         $display("FAIL run_entry: o_load=%b o_running=%b, expected 0 1", load_a, running_a);
      end
      c0 = cyc;
      for (int l = 0; l < 4; l++) cnt[l] = 0;
      for (int c = 1; c <= 96; c++) begin
         step();
         for (int l = 0; l < 4; l++) begin
            if (step_a[l] === 1'b1) begin
               if (cnt[l] < 8) tm[l][cnt[l]] = c;
               cnt[l]++;
            end
         end
      end
      for (int l = 0; l < 4; l++) begin
         vectors++;
         ok = (cnt[l] == exp_cnt[l]);
         for (int k = 0; k < exp_cnt[l] && k < cnt[l] && k < 8; k++)
            if (tm[l][k] != (k + 1) * exp_per[l]) ok = 1'b0;
         if (!ok) begin
            errors++;
            $display("FAIL lane_rate lane%0d: %0d strobes first at %0d, expected %0d strobes every %0d cycles",
                     l, cnt[l], tm[l][0], exp_cnt[l], exp_per[l]);
         end
      end
   endtask

   task automatic test_pause();
      bit quiet;
      int t;
      step(); step();
      pause = 1'b1; step(); pause = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) step();
         if (step_a !== 4'd0 || running_a !== 1'b0) quiet = 1'b0;
      end
      vectors++;
      if (!quiet) begin
         errors++;
         $display("FAIL pause_freeze: strobes or o_running seen while paused, expected none");
      end
      pause = 1'b1; step(); pause = 1'b0;
      vectors++;
      if (running_a !== 1'b1) begin
         errors++;
         $display("FAIL pause_resume: o_running=%b, expected 1", running_a);
      end
      t = -1;
      for (int i = 0; i < 40; i++) begin
         if (step_a[1] === 1'b1) begin
            t = cyc - c0;
            break;
         end
         step();
      end
      vectors++;
      if (t != 152) begin
         errors++;
         $display("FAIL pause_shift: lane1 strobe at %0d, expected 152", t);
      end
   endtask

   task automatic wait_run();
      for (int i = 0; i < 8; i++) begin
         if (running_a === 1'b1) return;
         step();
      end
      vectors++;
      errors++;
      $display("FAIL wait_run: o_running never returned, expected 1");
   endtask

   task automatic test_level();
      int loads;
      int c1;
      int n0, n1, f0, f1;
      bit ok0, ok1;
      loads = 0;
      for (int k = 0; k < 5; k++) begin
         level_up = 1'b1; step(); level_up = 1'b0;
         if (load_a === 1'b1) loads++;
         step();
         wait_run();
      end
      vectors++;
      if (level_a !== 3'd5 || loads != 5) begin
         errors++;
         $display("FAIL level_five: o_level=%0d loads=%0d, expected 5 5", level_a, loads);
      end
      c1 = cyc;
      n0 = 0; n1 = 0; f0 = -1; f1 = -1; ok0 = 1'b1; ok1 = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         step();
         if (step_a[0] === 1'b1) begin
            if (c % 12 != 0) ok0 = 1'b0;
            if (f0 < 0) f0 = c;
            n0++;
         end
         if (step_a[1] === 1'b1) begin
            if (c % 4 != 0) ok1 = 1'b0;
            if (f1 < 0) f1 = c;
            n1++;
         end
      end
      vectors++;
      if (!ok0 || n0 != 2 || f0 != 12) begin
         errors++;
         $display("FAIL level_lane0: %0d strobes first at %0d, expected 2 strobes every 12", n0, f0);
      end
      vectors++;
      if (!ok1 || n1 != 6 || f1 != 4) begin
         errors++;
         $display("FAIL level_lane1: %0d strobes first at %0d, expected 6 strobes every 4", n1, f1);
      end
      for (int k = 0; k < 2; k++) begin
         level_up = 1'b1; step(); level_up = 1'b0; step(); wait_run();
      end
      vectors++;
      if (level_a !== 3'd7) begin
         errors++;
         $display("FAIL level_seven: o_level=%0d, expected 7", level_a);
      end
      level_up = 1'b1; step(); level_up = 1'b0; step(); wait_run();
      vectors++;
      if (level_a !== 3'd7) begin
         errors++;
         $display("FAIL level_saturate: o_level=%0d, expected 7", level_a);
      end
   endtask

   task automatic test_game_over();
      bit quiet;
      game_over = 1'b1; level_up = 1'b1; step(); game_over = 1'b0; level_up = 1'b0;
      vectors++;
      if (level_a !== 3'd7 || load_a !== 1'b0 || running_a !== 1'b0 || step_a !== 4'd0) begin
         errors++;
         $display("FAIL game_over_prio: level=%0d load=%b run=%b step=%b, expected 7 0 0 0000",
                  level_a, load_a, running_a, step_a);
      end
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (step_a !== 4'd0 || load_a !== 1'b0 || running_a !== 1'b0 || level_a !== 3'd7) quiet = 1'b0;
      end
      vectors++;
      if (!quiet) begin
         errors++;
         $display("FAIL game_over_idle: activity or level change after game over, expected idle with level 7");
      end
      start = 1'b1; step(); start = 1'b0;
      vectors++;
      if (load_a !== 1'b1 || level_a !== 3'd0) begin
         errors++;
         $display("FAIL restart: o_load=%b o_level=%0d, expected 1 0", load_a, level_a);
      end
      step();
      vectors++;
      if (running_a !== 1'b1) begin
         errors++;
         $display("FAIL restart_run: o_running=%b, expected 1", running_a);
      end
   endtask

   task automatic test_disabled_reset();
      int n1, f1;
      bit ok1, quiet;
      start_b = 1'b1; step(); start_b = 1'b0;
      vectors++;
      if (load_b !== 1'b1) begin
         errors++;
         $display("FAIL b_load: o_load=%b, expected 1", load_b);
      end
      step();
      n1 = 0; f1 = -1; ok1 = 1'b1; quiet = 1'b1;
      for (int c = 1; c <= 63; c++) begin
         step();
         if (step_b[0] === 1'b1 || step_b[3:2] !== 2'b00) quiet = 1'b0;
         if (step_b[1] === 1'b1) begin
            if (c % 16 != 0) ok1 = 1'b0;
            if (f1 < 0) f1 = c;
            n1++;
         end
      end
      vectors++;
      if (!quiet) begin
         errors++;
         $display("FAIL disabled_lane: strobe on a zero-period lane, expected none");
      end
      vectors++;
      if (!ok1 || n1 != 3 || f1 != 16) begin
         errors++;
         $display("FAIL b_lane1_rate: %0d strobes first at %0d, expected 3 strobes every 16", n1, f1);
      end
      rst_b = 1'b1; step(); rst_b = 1'b0;
      vectors++;
      if (step_b !== 4'd0 || running_b !== 1'b0 || load_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_suppress: step=%b run=%b load=%b, expected 0000 0 0", step_b, running_b, load_b);
      end
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if ({step_b, load_b, level_b, running_b} !== 9'd0) quiet = 1'b0;
      end
      vectors++;
      if (!quiet) begin
         errors++;
         $display("FAIL reset_idle: activity after mid-run reset, expected all 0");
      end
   endtask

   initial begin
      test_reset();
      test_start_rates();
      test_pause();
      test_level();
      test_game_over();
      test_disabled_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
